// File: rtl/tl_ul_scratch_slave.sv
// Single-beat TileLink-UL slave over a word-organised scratch RAM.
// Latency 1 (registered D response); a_ready = !d_valid | d_ready, so a stalled D stalls A.
module tl_ul_scratch_slave #(
    parameter int                ADDR_W      = 15,
    parameter int                SRC_W       = 2,
    parameter int                DEPTH_WORDS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [2:0]        a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [3:0]        a_mask,
    input  logic [31:0]       a_data,
    input  logic              a_corrupt,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_param,
    output logic [2:0]        d_size,
    output logic [SRC_W-1:0]  d_source,
    output logic              d_denied,
    output logic [31:0]       d_data,
    output logic              d_corrupt,
    output logic [7:0]        err_count
);

    localparam int                IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    logic [31:0]       mem [DEPTH_WORDS];
    logic              a_fire;
    logic              d_fire;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word_off;
    logic [IDX_W-1:0]  idx;
    logic              out_of_range;
    logic              misaligned;
    logic              op_ok;
    logic              is_get;
    logic              is_put;
    logic              denied;
    logic              wr_en;

    assign a_ready = !d_valid || d_ready;
    assign a_fire  = a_valid && a_ready;
    assign d_fire  = d_valid && d_ready;

    assign offset       = a_address - BASE_ADDR;
    assign word_off     = offset >> 2;
    assign idx          = word_off[IDX_W-1:0];
    assign out_of_range = (a_address < BASE_ADDR) || (word_off >= DEPTH_LIM);

    assign is_get = (a_opcode == OP_GET);
    assign is_put = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
    assign op_ok  = is_get || is_put;

    always_comb begin
        misaligned = 1'b0;
        case (a_size)
            3'd1:    misaligned = a_address[0];
            3'd2:    misaligned = |a_address[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign denied = !op_ok || (a_param != 3'd0) || (a_size > 3'd2) || misaligned || out_of_range;

    // Poisoned write data is dropped silently; the request is still acknowledged as legal.
    assign wr_en = a_fire && !denied && is_put && !a_corrupt;

    // Reset only gates the write strobe so an A fire during reset cannot corrupt the RAM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (a_mask[i]) begin
                    mem[idx][8*i +: 8] <= a_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_valid   <= 1'b0;
            d_opcode  <= 3'd0;
            d_param   <= 2'd0;
            d_size    <= 3'd0;
            d_source  <= '0;
            d_denied  <= 1'b0;
            d_data    <= 32'd0;
            d_corrupt <= 1'b0;
        end else if (a_fire) begin
            d_valid   <= 1'b1;
            d_opcode  <= is_get ? OP_ACK_DATA : OP_ACK;
            d_param   <= 2'd0;
            d_size    <= a_size;
            d_source  <= a_source;
            d_denied  <= denied;
            d_data    <= (is_get && !denied) ? mem[idx] : 32'd0;
            d_corrupt <= is_get && denied;
        end else if (d_fire) begin
            d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count <= 8'd0;
        end else if (d_fire && d_denied && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_tl_ul_scratch_slave.sv
// Directed bench for tl_ul_scratch_slave: expected D beats queued at A fire, checked by a D-side monitor.
module tb_tl_ul_scratch_slave;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [1:0]  src;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [2:0]  a_size = '0;
    logic [1:0]  a_source = '0;
    logic [14:0] a_address = '0;
    logic [3:0]  a_mask = '0;
    logic [31:0] a_data = '0;
    logic        a_corrupt = 1'b0;
    logic        d_valid;
    logic        d_ready = 1'b1;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [1:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic [7:0]  err_count;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cycles = 0;

    tl_ul_scratch_slave #(
        .ADDR_W(15), .SRC_W(2), .DEPTH_WORDS(256), .BASE_ADDR(15'h0000)
    ) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .a_corrupt(a_corrupt),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
        .d_corrupt(d_corrupt), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic rsp_t mk(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                                input logic denied, input logic [31:0] data, input logic corrupt);
        rsp_t r;
        r.op = op; r.size = size; r.src = src; r.denied = denied; r.data = data; r.corrupt = corrupt;
        return r;
    endfunction

    // Monitor: every D fire pops one expected beat.
    always @(negedge clock) begin
        if (reset && d_valid && d_ready) begin
            if (exp_q.size() == 0) begin
                chk("d_unexpected_beat", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("d_opcode", 32'(d_opcode), 32'(e.op));
                chk("d_param", 32'(d_param), 32'd0);
                chk("d_size", 32'(d_size), 32'(e.size));
                chk("d_source", 32'(d_source), 32'(e.src));
                chk("d_denied", 32'(d_denied), 32'(e.denied));
                chk("d_data", d_data, e.data);
                chk("d_corrupt", 32'(d_corrupt), 32'(e.corrupt));
            end
        end
    end

    // Called just after a posedge; returns just after the posedge on which A fired.
    task automatic send(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                        input logic [1:0] src, input logic [14:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic corrupt, input rsp_t e);
        logic fired;
        logic rdy;
        fired = 1'b0;
        a_opcode = op; a_param = param; a_size = size; a_source = src;
        a_address = addr; a_mask = mask; a_data = data; a_corrupt = corrupt;
        a_valid = 1'b1;
        for (int n = 0; n < 50 && !fired; n++) begin
            @(negedge clock);
            rdy = a_ready;
            @(posedge clock);
            if (rdy) fired = 1'b1;
            else stall_cycles++;
        end
        #1;
        a_valid = 1'b0;
        if (fired) exp_q.push_back(e);
        else chk("a_fire_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clock);
        #1;
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_d_fields", {d_opcode, d_param, d_size, d_source, d_denied, d_corrupt}, 32'd0);
        chk("rst_d_data", d_data, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        // Put then Get, then partial write over the same word
        send(3'd0, 3'd0, 3'd2, 2'd1, 15'h0010, 4'hF, 32'hDEADBEEF, 1'b0, mk(3'd0, 3'd2, 2'd1, 1'b0, 32'd0, 1'b0));
        send(3'd4, 3'd0, 3'd2, 2'd2, 15'h0010, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd2, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0));
        send(3'd1, 3'd0, 3'd1, 2'd0, 15'h0012, 4'hC, 32'h12340000, 1'b0, mk(3'd0, 3'd1, 2'd0, 1'b0, 32'd0, 1'b0));
        send(3'd4, 3'd0, 3'd2, 2'd3, 15'h0010, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd2, 2'd3, 1'b0, 32'h1234BEEF, 1'b0));

        // Illegal requests
        send(3'd4, 3'd0, 3'd2, 2'd3, 15'h0400, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd2, 2'd3, 1'b1, 32'd0, 1'b1));
        send(3'd4, 3'd0, 3'd3, 2'd1, 15'h0010, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd3, 2'd1, 1'b1, 32'd0, 1'b1));
        send(3'd2, 3'd0, 3'd2, 2'd2, 15'h0010, 4'hF, 32'h0BADF00D, 1'b0, mk(3'd0, 3'd2, 2'd2, 1'b1, 32'd0, 1'b0));
        drain();
        chk("err_count_after_3", 32'(err_count), 32'd3);

        // Misaligned, nonzero param, poisoned put (acked, not written)
        send(3'd4, 3'd0, 3'd2, 2'd0, 15'h0011, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd2, 2'd0, 1'b1, 32'd0, 1'b1));
        send(3'd4, 3'd1, 3'd2, 2'd1, 15'h0010, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd2, 2'd1, 1'b1, 32'd0, 1'b1));
        send(3'd0, 3'd0, 3'd2, 2'd2, 15'h0010, 4'hF, 32'h0, 1'b1, mk(3'd0, 3'd2, 2'd2, 1'b0, 32'd0, 1'b0));
        send(3'd4, 3'd0, 3'd2, 2'd3, 15'h0010, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd2, 2'd3, 1'b0, 32'h1234BEEF, 1'b0));
        drain();
        chk("err_count_after_5", 32'(err_count), 32'd5);

        // Streaming: 16 puts then 16 gets, back to back
        stall_cycles = 0;
        for (int i = 0; i < 16; i++)
            send(3'd0, 3'd0, 3'd2, 2'(i), 15'(12'h100 + 4 * i), 4'hF, 32'hA5000000 | 32'(i), 1'b0,
                 mk(3'd0, 3'd2, 2'(i), 1'b0, 32'd0, 1'b0));
        for (int i = 0; i < 16; i++)
            send(3'd4, 3'd0, 3'd2, 2'(i), 15'(12'h100 + 4 * i), 4'hF, 32'd0, 1'b0,
                 mk(3'd1, 3'd2, 2'(i), 1'b0, 32'hA5000000 | 32'(i), 1'b0));
        chk("stream_stall_cycles", 32'(stall_cycles), 32'd0);
        drain();

        // Backpressure then simultaneous A/D fire
        d_ready = 1'b0;
        send(3'd4, 3'd0, 3'd2, 2'd1, 15'h0010, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd2, 2'd1, 1'b0, 32'h1234BEEF, 1'b0));
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("bp_a_ready", 32'(a_ready), 32'd0);
            chk("bp_d_valid", 32'(d_valid), 32'd1);
            chk("bp_d_data", d_data, 32'h1234BEEF);
            chk("bp_d_source", 32'(d_source), 32'd1);
        end
        @(posedge clock); #1;
        d_ready = 1'b1;
        send(3'd4, 3'd0, 3'd2, 2'd2, 15'h0104, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd2, 2'd2, 1'b0, 32'hA5000001, 1'b0));
        chk("bp_d_valid_after_dual_fire", 32'(d_valid), 32'd1);
        drain();

        // Saturation
        for (int i = 0; i < 300; i++)
            send(3'd4, 3'd0, 3'd2, 2'(i), 15'h0400, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd2, 2'(i), 1'b1, 32'd0, 1'b1));
        drain();
        chk("err_count_saturated", 32'(err_count), 32'hFF);

        // Reset with a pending response; a put presented during reset must not land
        d_ready = 1'b0;
        send(3'd4, 3'd0, 3'd2, 2'd3, 15'h0010, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd2, 2'd3, 1'b0, 32'h1234BEEF, 1'b0));
        chk("pre_reset_d_valid", 32'(d_valid), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_reset_d_valid", 32'(d_valid), 32'd0);
        chk("mid_reset_err_count", 32'(err_count), 32'd0);
        chk("mid_reset_d_data", d_data, 32'd0);
        exp_q.delete();
        a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd2; a_address = 15'h0010;
        a_mask = 4'hF; a_data = 32'h0; a_corrupt = 1'b0; a_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        a_valid = 1'b0;
        d_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        send(3'd4, 3'd0, 3'd2, 2'd0, 15'h0010, 4'hF, 32'd0, 1'b0, mk(3'd1, 3'd2, 2'd0, 1'b0, 32'h1234BEEF, 1'b0));
        drain();
        chk("post_reset_err_count", 32'(err_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
